// File: rtl/freq_pkg.sv
// Shared types and default constants for the period-to-frequency divider.
// Optional feature macro: DIV_ROUND_EN (adds the ROUND state).
package freq_pkg;

    localparam int unsigned DVSR_W_DEF   = 16;
    localparam int unsigned DVND_W_DEF   = 20;
    localparam int unsigned DIVIDEND_DEF = 1_000_000;

`ifdef DIV_ROUND_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OP    = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OP    = 2'd1,
        S_DONE  = 2'd3
    } div_state_t;
`endif

endpackage

// File: rtl/period_to_freq_divider.sv
// Restoring divider: freq_o = DIVIDEND / period_i, one quotient bit per clock.
// Optional feature macro: DIV_ROUND_EN (round-half-up of the quotient, +1 cycle).
module period_to_freq_divider
    import freq_pkg::*;
#(
    parameter int unsigned DVSR_W   = DVSR_W_DEF,
    parameter int unsigned DVND_W   = DVND_W_DEF,
    parameter int unsigned DIVIDEND = DIVIDEND_DEF
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [DVSR_W-1:0] period_i,
    output logic              ready_o,
    output logic              done_o,
    output logic [DVND_W-1:0] freq_o,
    output logic [DVSR_W-1:0] rem_o,
    output logic              dbz_o
);

    localparam int unsigned CNT_W = $clog2(DVND_W + 1);
    localparam logic [DVND_W-1:0] DVND_VAL = DVND_W'(DIVIDEND);

    div_state_t        state_q, state_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic [DVND_W-1:0] quot_q, quot_d;
    logic [DVSR_W-1:0] prem_q, prem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              zflag_q, zflag_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [DVND_W-1:0] freq_q, freq_d;
    logic [DVSR_W-1:0] rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic [DVSR_W:0]   trial;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            dvsr_q  <= '0;
            quot_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            freq_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state, compare/subtract step, and result publication on entry to DONE.
    always_comb begin
        state_d = state_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        freq_d  = freq_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        trial   = {prem_q, quot_q[DVND_W-1]};

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (period_i != '0) begin
                        dvsr_d  = period_i;
                        quot_d  = DVND_VAL;
                        prem_d  = '0;
                        cnt_d   = CNT_W'(DVND_W);
                        zflag_d = 1'b0;
                        state_d = S_OP;
                    end else begin
                        // Divide by zero: saturated quotient, no iterations.
                        quot_d  = '1;
                        prem_d  = '0;
                        zflag_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_OP: begin
                if (trial >= {1'b0, dvsr_q}) begin
                    prem_d = DVSR_W'(trial - {1'b0, dvsr_q});
                    quot_d = {quot_q[DVND_W-2:0], 1'b1};
                end else begin
                    prem_d = trial[DVSR_W-1:0];
                    quot_d = {quot_q[DVND_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_ROUND_EN
                    state_d = S_ROUND;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef DIV_ROUND_EN
            S_ROUND: begin
                // Round half up; the remainder stays the truncated one.
                if (({prem_q, 1'b0} >= {1'b0, dvsr_q}) && (quot_q != '1)) begin
                    quot_d = quot_q + DVND_W'(1);
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs update together with the done pulse.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            freq_d = quot_d;
            rem_d  = prem_d;
            dbz_d  = zflag_d;
            done_d = 1'b1;
        end

        ready_d = (state_d == S_IDLE);
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign freq_o  = freq_q;
    assign rem_o   = rem_q;
    assign dbz_o   = dbz_q;

endmodule

// File: tb/tb_period_to_freq_divider.sv
// Self-checking bench for period_to_freq_divider (optionally with DIV_ROUND_EN).
module tb_period_to_freq_divider;

    localparam int unsigned DVSR_W   = 16;
    localparam int unsigned DVND_W   = 20;
    localparam longint      DIVIDEND = 1000000;
    localparam longint      QMAX     = (64'd1 << DVND_W) - 1;
`ifdef DIV_ROUND_EN
    localparam int LAT = DVND_W + 2;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = DVND_W + 1;
    localparam bit RND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_ni;
    logic              start_i;
    logic [DVSR_W-1:0] period_i;
    logic              ready_o;
    logic              done_o;
    logic [DVND_W-1:0] freq_o;
    logic [DVSR_W-1:0] rem_o;
    logic              dbz_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    period_to_freq_divider dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .start_i  (start_i),
        .period_i (period_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .freq_o   (freq_o),
        .rem_o    (rem_o),
        .dbz_o    (dbz_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic for one operation.
    function automatic void ref_div(input longint p, output longint f, output longint r,
                                    output bit z);
        if (p == 0) begin
            f = QMAX; r = 0; z = 1'b1;
        end else begin
            f = DIVIDEND / p;
            r = DIVIDEND % p;
            z = 1'b0;
            if (RND && (2 * r >= p) && (f < QMAX)) f = f + 1;
        end
    endfunction

    // Transaction-level model: idle / busy countdown / done, with held results.
    int     m_phase;   // 0 idle, 1 busy, 2 done
    int     m_left;
    longint m_freq, m_rem;
    bit     m_dbz;
    longint p_freq, p_rem;
    bit     p_dbz;

    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_phase = 0; m_left = 0; m_freq = 0; m_rem = 0; m_dbz = 1'b0;
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    ref_div(longint'(period_i), p_freq, p_rem, p_dbz);
                    m_left = (period_i == 0) ? 0 : LAT - 1;
                    if (m_left == 0) begin
                        m_phase = 2; m_freq = p_freq; m_rem = p_rem; m_dbz = p_dbz;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2; m_freq = p_freq; m_rem = p_rem; m_dbz = p_dbz;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (reset_ni) begin
            check("cyc_ready", longint'(ready_o), longint'(m_phase == 0));
            check("cyc_done",  longint'(done_o),  longint'(m_phase == 2));
            check("cyc_freq",  longint'(freq_o),  m_freq);
            check("cyc_rem",   longint'(rem_o),   m_rem);
            check("cyc_dbz",   longint'(dbz_o),   longint'(m_dbz));
        end
    end

    // One directed operation with hand-computed expectations.
    task automatic run_op(input logic [DVSR_W-1:0] p, input longint ef, input longint er,
                          input bit ez, input int elat);
        int n;
        @(negedge clk);
        start_i  = 1'b1;
        period_i = p;
        @(negedge clk);
        start_i  = 1'b0;
        period_i = DVSR_W'($urandom);
        n = 1;
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lat_p%0d", p), n, elat);
        check($sformatf("freq_p%0d", p), longint'(freq_o), ef);
        check($sformatf("rem_p%0d", p), longint'(rem_o), er);
        check($sformatf("dbz_p%0d", p), longint'(dbz_o), longint'(ez));
        @(negedge clk);
        check($sformatf("ready_after_p%0d", p), longint'(ready_o), 1);
    endtask

    initial begin
        int n;
        int dones;
        reset_ni = 1'b0;
        start_i  = 1'b0;
        period_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", longint'(ready_o), 1);
        check("rst_done",  longint'(done_o),  0);
        check("rst_freq",  longint'(freq_o),  0);
        check("rst_rem",   longint'(rem_o),   0);
        check("rst_dbz",   longint'(dbz_o),   0);
        @(posedge clk);
        #2 reset_ni = 1'b1;

        run_op(16'd1000,  1000,   0,     1'b0, 21 + int'(RND));
        run_op(16'd7,     142857, 1,     1'b0, LAT);
        run_op(16'd6,     RND ? 166667 : 166666, 4, 1'b0, LAT);
        run_op(16'd65535, 15,     16975, 1'b0, LAT);
        run_op(16'd1,     1000000, 0,    1'b0, LAT);
        run_op(16'd0,     20'hFFFFF, 0,  1'b1, 1);
        run_op(16'd500,   2000,   0,     1'b0, LAT);

        // Start pulse during OP must be ignored.
        @(negedge clk);
        start_i = 1'b1; period_i = 16'd1000;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        start_i = 1'b1; period_i = 16'd2;
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midop_freq", longint'(freq_o), 1000);
        check("midop_rem",  longint'(rem_o),  0);
        @(negedge clk);

        // start_i held high: re-accepted on the first IDLE cycle.
        start_i = 1'b1; period_i = 16'd7;
        dones = 0;
        for (int i = 0; i < 2 * (LAT + 1); i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        start_i = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_ready", longint'(ready_o), 1);
        repeat (2) @(negedge clk);

        // Reset mid-operation: immediate reset values, no done for the aborted op.
        start_i = 1'b1; period_i = 16'd1000;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset_ni = 1'b0;
        #1;
        check("abort_ready", longint'(ready_o), 1);
        check("abort_done",  longint'(done_o),  0);
        check("abort_freq",  longint'(freq_o),  0);
        check("abort_rem",   longint'(rem_o),   0);
        check("abort_dbz",   longint'(dbz_o),   0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset_ni = 1'b1;
        dones = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("abort_no_done", dones, 0);

        run_op(16'd500, 2000, 0, 1'b0, LAT);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/period_to_freq_divider.md
# period_to_freq_divider

Sequential restoring divider that converts a measured period into a frequency: freq = DIVIDEND / period. It sits directly downstream of the period counter in the auto-scaled low-frequency counter path. It takes the counter's 16-bit period on a start pulse and hands a frequency word to the BCD/display stage with a one-cycle done pulse. It computes one quotient bit per clock and accepts a new operand only when idle.

## Interface
- DVSR_W, 16: period (divisor) width; matches the period counter output.
- DVND_W, 20: dividend and quotient width.
- DIVIDEND, 1_000_000: numerator constant (timebase ticks per second); must fit in DVND_W bits.

- clk_i  input  1  single clock; all state on rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only while ready_o=1.
- period_i  input  DVSR_W  divisor; captured on accepted start.
- ready_o  output  1  high in IDLE only.
- done_o  output  1  one-cycle pulse when freq_o/rem_o/dbz_o update.
- freq_o  output  DVND_W  quotient, held until next completion.
- rem_o  output  DVSR_W  remainder, held until next completion.
- dbz_o  output  1  divide-by-zero flag of last operation, held.

## Operation
- States: IDLE, OP, DONE (plus ROUND when DIV_ROUND_EN).
- IDLE: ready_o=1. When start_i=1:
  - If period_i≠0: load divisor=period_i, quotient shift register=DIVIDEND, partial remainder=0, iteration count=DVND_W, then go to OP.
  - If period_i=0: set the internal dbz flag and go to DONE directly.
- OP, each cycle:
  - Form {rem, msb(quot)}, which is DVSR_W+1 bits wide.
  - If that value ≥ divisor: subtract the divisor and shift 1 into quot. Otherwise shift 0.
  - Decrement the count. The cycle with count=1 moves to DONE (or ROUND).
- DONE: done_o=1. freq_o, rem_o and dbz_o load from internal registers. Return to IDLE.
- Divide by zero: freq_o = all ones, rem_o = 0, dbz_o = 1.
- start_i outside IDLE is ignored. No queueing.
- period_i is don't-care except on the accepted start edge.
- Quotient cannot overflow, because divisor ≥ 1.

## Timing
- Reset values: state IDLE, ready_o=1, done_o=0, freq_o=0, rem_o=0, dbz_o=0, all internal registers 0.
- Latency, nonzero divisor: done_o is high in the cycle after DVND_W+1 rising edges following the start-sampling edge. That is edge 0 (accept), edges 1..DVND_W (iterations), then DONE. With ROUND, add 1 cycle.
- Latency, divisor zero: done_o is high in the cycle immediately after the accept edge.
- ready_o falls the cycle after accept and rises the cycle after done_o.
- Back-to-back: start_i held high continuously is re-accepted on the first IDLE cycle. The minimum issue interval is DVND_W+2 cycles.
- Reset asserted mid-operation returns the block to reset values immediately. No done_o is produced for the aborted operation.

## Configuration
- DIV_ROUND_EN defined:
  - Adds a ROUND state between OP and DONE.
  - If 2·rem ≥ divisor, the quotient is incremented, saturating at all ones, and rem_o reports the pre-round remainder.
  - Latency grows by 1 cycle.
- DIV_ROUND_EN undefined: the result is truncated, there is no ROUND state, and latency is as above.

## Structure
- Shared package freq_pkg holds:
  - the state enum typedef (div_state_t);
  - default constants DVSR_W_DEF=16, DVND_W_DEF=20, DIVIDEND_DEF=1_000_000.
- Single module: one always_ff register block plus one always_comb next-state/datapath block.
- No sub-module is warranted. The compare/subtract step is inline.

## Test plan
- period_i=1000 -> freq_o=1000, rem_o=0, dbz_o=0, done_o exactly 21 cycles after accept.
- period_i=7 -> freq_o=142857, rem_o=1.
- period_i=6 -> freq_o=166666, rem_o=4 without DIV_ROUND_EN. With it, freq_o=166667 and done_o arrives 1 cycle later.
- period_i=65535 -> freq_o=15, rem_o=16975. period_i=1 -> freq_o=1_000_000, rem_o=0.
- period_i=0 -> done_o the cycle after accept, freq_o=20'hFFFFF, dbz_o=1. A following period_i=500 clears dbz_o and gives freq_o=2000.
- start_i pulsed mid-OP with period_i=2 -> ignored, first result intact. reset_ni low mid-OP -> all outputs at reset values, no done_o, ready_o=1.
